instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Multicycle fetch stage sitting directly upstream of controlLogic.
//  - Holds PC and the instruction register (IR); fetches each word over a req/ack memory handshake.
//  - Splits the IR into opcode/funct/fields for the control logic.
//  - Waits for the control logic to retire the instruction, then selects the next PC.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC value loaded on reset
//  ADDR_W     32              PC / memory address width (bits)
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-low reset
//  imem_req    out  1       instruction memory read request
//  imem_addr   out  ADDR_W  read address (always == pc)
//  imem_ack    in   1       read data valid this cycle
//  imem_rdata  in   32      instruction word
//  instr_done  in   1       control logic has finished the current instruction
//  jump        in   1       J/JAL from control
//  jr          in   1       JR from control (funct 6'h08)
//  beq         in   1       BEQ from control
//  bne         in   1       BNE from control
//  zero        in   1       ALU zero flag for the current instruction
//  rs_data     in   32      register-file rs value (JR target)
//  ir_valid    out  1       IR holds a fetched, unretired instruction
//  opcode      out  6       IR[31:26]
//  rs          out  5       IR[25:21]
//  rt          out  5       IR[20:16]
//  rd          out  5       IR[15:11]
//  funct       out  6       IR[5:0]
//  imm         out  16      IR[15:0]
//  target      out  26      IR[25:0]
//  pc          out  ADDR_W  address of the current instruction
//  pc_plus4    out  ADDR_W  pc + 4 (JAL link value)
//  misalign    out  1       one-cycle pulse: JR target had rs_data[1:0] != 0
// BEHAVIOUR
//  Reset (reset==0, asynchronous): pc=RESET_PC, IR=0, state=FETCH.
//    Outputs during reset: imem_req=0, ir_valid=0, misalign=0.
//    Field outputs read 0; pc_plus4 = RESET_PC+4.
//  FSM: FETCH -> DECODE -> UPDATE -> FETCH.
//  - FETCH: imem_req=1, imem_addr=pc.
//    - imem_ack=1: IR <= imem_rdata, next DECODE; ack may arrive in the first cycle of FETCH.
//    - imem_ack=0: stay in FETCH with req held high and addr held stable.
//  - DECODE: imem_req=0, ir_valid=1, IR fields stable.
//    - Stays until instr_done=1.
//    - jump/jr/beq/bne/zero/rs_data are sampled on the instr_done edge into next_pc.
//  - UPDATE: ir_valid=0; pc <= next_pc; next state FETCH. Fixed one cycle.
//  Minimum cycles per instruction: 3 (1 FETCH + 1 DECODE + 1 UPDATE).
//  next_pc priority:
//    1. jr=1               -> {rs_data[31:2],2'b00}
//    2. jump=1             -> {pc_plus4[31:28], target, 2'b00}
//    3. beq&zero | bne&~zero -> pc_plus4 + {{14{imm[15]}}, imm, 2'b00}
//    4. otherwise          -> pc_plus4
//  Simultaneous flags: resolved by the priority above; no error raised.
//  Arithmetic is modulo 2^ADDR_W; PC and branch sums wrap silently (0xFFFFFFFC+4 -> 0).
//  misalign: pulses high in the UPDATE cycle when JR is taken with rs_data[1:0] != 0.
//  Fields and pc are stable while ir_valid=1; instr_done outside DECODE is ignored.
//  imem_ack outside FETCH is ignored and the IR is not overwritten.
//  Reset mid-fetch or mid-decode aborts immediately; the first req after release uses RESET_PC.
// TESTING
//  1 Reset, zero-wait ack, instr_done 1 cycle into each DECODE.
//    -> imem_addr 0,4,8; 3 cycles/instr.
//  2 IR=32'h0000002A (SLT).
//    -> opcode=00, funct=2A, rs=0, rd=0; next pc=pc+4.
//  3 pc=0x40, BEQ imm=16'hFFFF, zero=1 -> pc=0x40.
//    BNE imm=16'h0004, zero=1 -> pc=0x44 (branch not taken).
//  4 pc=0x1000_0010, J target=26'h0000040 -> pc=0x1000_0100.
//    JAL: pc_plus4=0x1000_0014 while in DECODE.
//  5 JR with rs_data=0x103, jump=1 simultaneously
//    -> pc=0x100, misalign pulse 1 cycle (JR wins).
//  6 imem_ack delayed 3 cycles -> req/addr held; reset low during wait
//    -> req=0 at once; after release, fetch at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - multicycle fetch stage: PC, IR, field split and next-PC selection
module instr_fetch_unit #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              instr_done,
    input  logic              jump,
    input  logic              jr,
    input  logic              beq,
    input  logic              bne,
    input  logic              zero,
    input  logic [31:0]       rs_data,
    output logic              ir_valid,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        funct,
    output logic [15:0]       imm,
    output logic [25:0]       target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              misalign
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] next_pc_q, next_pc_d;
    logic              misalign_q, misalign_d;

    logic [ADDR_W-1:0] pc_plus4_w;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] jump_tgt;
    logic [31:0]       jr_word;
    logic [ADDR_W-1:0] jr_tgt;
    logic              br_taken;
    logic              sample;

    // Target candidates for the next PC, all derived from the held IR and PC.
    always_comb begin
        pc_plus4_w      = pc_q + ADDR_W'(4);
        br_off          = {{(ADDR_W-18){ir_q[15]}}, ir_q[15:0], 2'b00};
        br_tgt          = pc_plus4_w + br_off;
        jump_tgt        = pc_plus4_w;
        jump_tgt[27:0]  = {ir_q[25:0], 2'b00};
        jr_word         = {rs_data[31:2], 2'b00};
        jr_tgt          = ADDR_W'(jr_word);
        br_taken        = (beq & zero) | (bne & ~zero);
        sample          = (state_q == S_DECODE) & instr_done;
    end

    // State register; reset aborts any fetch or decode in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: FETCH waits for ack, DECODE waits for retire, UPDATE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (imem_ack)   state_d = S_DECODE;
            S_DECODE: if (instr_done) state_d = S_UPDATE;
            S_UPDATE: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Datapath registers: PC, IR, the sampled next PC and the misalign flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            next_pc_q  <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            next_pc_q  <= next_pc_d;
            misalign_q <= misalign_d;
        end
    end

    // Datapath update: capture the word on ack, pick next PC at retire, commit it in UPDATE.
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        next_pc_d  = next_pc_q;
        misalign_d = 1'b0;
        if ((state_q == S_FETCH) && imem_ack) begin
            ir_d = imem_rdata;
        end
        if (sample) begin
            // JR outranks J, which outranks a taken branch.
            if (jr) begin
                next_pc_d  = jr_tgt;
                misalign_d = |rs_data[1:0];
            end else if (jump) begin
                next_pc_d = jump_tgt;
            end else if (br_taken) begin
                next_pc_d = br_tgt;
            end else begin
                next_pc_d = pc_plus4_w;
            end
        end
        if (state_q == S_UPDATE) begin
            pc_d = next_pc_q;
        end
    end

    // Output decode: handshake, IR fields and PC views.
    always_comb begin
        imem_req  = (state_q == S_FETCH) & reset;
        imem_addr = pc_q;
        ir_valid  = (state_q == S_DECODE);
        opcode    = ir_q[31:26];
        rs        = ir_q[25:21];
        rt        = ir_q[20:16];
        rd        = ir_q[15:11];
        funct     = ir_q[5:0];
        imm       = ir_q[15:0];
        target    = ir_q[25:0];
        pc        = pc_q;
        pc_plus4  = pc_plus4_w;
        misalign  = misalign_q;
    end

endmodule
